// File: rtl/serout_shifter.sv
// serout_shifter: POKEY-style serial output (SEROUT) transmitter.
//
// Holds one CPU-written word in a holding register. It moves that word into
// a shift register and sends it as a frame: a start bit (0), then DATA_BITS
// data bits LSB first, then an optional parity bit, then STOP_BITS stop bits
// (1). Every bit boundary falls on an external bit-tick enable.
//
// Optional build macro:
//   SEROUT_PARITY_EN - builds the parity state and the accumulator. The
//                      parity bit is XOR(data) ^ parityOdd.
//
// Parameters:
//   DATA_BITS   data bits per frame (5..16)
//   STOP_BITS   stop bits per frame (1..2)
//
// Ports:
//   clk          system clock, rising edge
//   nReset       asynchronous active-low reset
//   sdoBitTick   one-cycle bit-period enable
//   sdoWr        one-cycle holding-register write strobe
//   sdoData      word captured on sdoWr
//   forceBreak   holds the line low without disturbing sequencing
//   parityOdd    parity sense (1 = odd); used only with SEROUT_PARITY_EN
//   sdo          serial line, idle high
//   sdoEmptyIrq  one-cycle pulse after the holding register moves to the shifter
//   sdoFinish    sequencer idle and holding register empty
//   sdoOverrun   one-cycle pulse after a write lands on a full holding register
//   sdoBusy      sequencer not idle
module serout_shifter #(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 nReset,
    input  logic                 sdoBitTick,
    input  logic                 sdoWr,
    input  logic [DATA_BITS-1:0] sdoData,
    input  logic                 forceBreak,
    input  logic                 parityOdd,
    output logic                 sdo,
    output logic                 sdoEmptyIrq,
    output logic                 sdoFinish,
    output logic                 sdoOverrun,
    output logic                 sdoBusy
);

    localparam int unsigned      CNT_W     = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_BITS);
    localparam logic [1:0]       LAST_STOP = 2'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef SEROUT_PARITY_EN
        PAR,
`endif
        STOP
    } state_t;

    state_t                 state_q, state_d;
    logic [DATA_BITS-1:0]   hold_q, hold_d;
    logic                   hold_full_q, hold_full_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [1:0]             stop_cnt_q, stop_cnt_d;
    logic                   sdo_q, sdo_d;
    logic                   empty_irq_q, empty_irq_d;
    logic                   overrun_q, overrun_d;
    logic                   transfer;
`ifdef SEROUT_PARITY_EN
    logic                   par_q, par_d;
`else
    logic                   unused_parity;
    assign unused_parity = parityOdd;
`endif

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            stop_cnt_q  <= '0;
            sdo_q       <= 1'b1;
            empty_irq_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef SEROUT_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            stop_cnt_q  <= stop_cnt_d;
            sdo_q       <= sdo_d;
            empty_irq_q <= empty_irq_d;
            overrun_q   <= overrun_d;
`ifdef SEROUT_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        stop_cnt_d  = stop_cnt_q;
        sdo_d       = sdo_q;
        transfer    = 1'b0;
`ifdef SEROUT_PARITY_EN
        par_d       = par_q;
`endif

        if (sdoBitTick) begin
            unique case (state_q)
                IDLE: begin
                    if (hold_full_q) transfer = 1'b1;
                end
                START: begin
                    sdo_d     = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = CNT_W'(1);
                    state_d   = DATA;
`ifdef SEROUT_PARITY_EN
                    par_d     = shift_q[0];
`endif
                end
                DATA: begin
                    if (bit_cnt_q < LAST_BIT) begin
                        sdo_d     = shift_q[0];
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
`ifdef SEROUT_PARITY_EN
                        par_d     = par_q ^ shift_q[0];
`endif
                    end else begin
`ifdef SEROUT_PARITY_EN
                        state_d    = PAR;
                        sdo_d      = par_q ^ parityOdd;
`else
                        state_d    = STOP;
                        sdo_d      = 1'b1;
                        stop_cnt_d = '0;
`endif
                    end
                end
`ifdef SEROUT_PARITY_EN
                PAR: begin
                    state_d    = STOP;
                    sdo_d      = 1'b1;
                    stop_cnt_d = '0;
                end
`endif
                STOP: begin
                    if (stop_cnt_q == LAST_STOP) begin
                        if (hold_full_q) begin
                            transfer = 1'b1;
                        end else begin
                            state_d = IDLE;
                            sdo_d   = 1'b1;
                        end
                    end else begin
                        stop_cnt_d = stop_cnt_q + 2'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (transfer) begin
            shift_d = hold_q;
            state_d = START;
            sdo_d   = 1'b0;
        end

        // A write on a transfer edge refills the holding register, so the
        // write takes priority over the transfer's clear.
        if (sdoWr) begin
            hold_d      = sdoData;
            hold_full_d = 1'b1;
        end else if (transfer) begin
            hold_full_d = 1'b0;
        end

        empty_irq_d = transfer;
        overrun_d   = sdoWr & hold_full_q & ~transfer;
    end

    assign sdo         = sdo_q & ~forceBreak;
    assign sdoEmptyIrq = empty_irq_q;
    assign sdoOverrun  = overrun_q;
    assign sdoBusy     = (state_q != IDLE);
    assign sdoFinish   = (state_q == IDLE) & ~hold_full_q;

endmodule

// File: tb/tb_serout_shifter.sv
`timescale 1ns/1ps
module tb_serout_shifter;

    localparam int DB = 8;
`ifdef SEROUT_PARITY_EN
    localparam int SB = 2;
    localparam int PB = 1;
`else
    localparam int SB = 1;
    localparam int PB = 0;
`endif
    localparam int FRAME_LEN = 1 + DB + PB + SB;

    logic          clk = 1'b0;
    logic          nReset = 1'b0;
    logic          sdoBitTick = 1'b0;
    logic          sdoWr = 1'b0;
    logic [DB-1:0] sdoData = '0;
    logic          forceBreak = 1'b0;
    logic          parityOdd = 1'b0;
    logic          sdo, sdoEmptyIrq, sdoFinish, sdoOverrun, sdoBusy;

    int checks = 0;
    int errors = 0;
    int irq_cnt = 0;
    int ovr_cnt = 0;
    logic line_q[$];

    serout_shifter #(.DATA_BITS(DB), .STOP_BITS(SB)) dut (
        .clk(clk), .nReset(nReset), .sdoBitTick(sdoBitTick), .sdoWr(sdoWr),
        .sdoData(sdoData), .forceBreak(forceBreak), .parityOdd(parityOdd),
        .sdo(sdo), .sdoEmptyIrq(sdoEmptyIrq), .sdoFinish(sdoFinish),
        .sdoOverrun(sdoOverrun), .sdoBusy(sdoBusy)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, take the edge, sample 1 ns later.
    task automatic cyc(input logic tk, input logic wr, input logic [DB-1:0] d);
        sdoBitTick = tk;
        sdoWr      = wr;
        sdoData    = d;
        @(posedge clk);
        #1;
        sdoBitTick = 1'b0;
        sdoWr      = 1'b0;
        if (sdoEmptyIrq === 1'b1) irq_cnt++;
        if (sdoOverrun === 1'b1) ovr_cnt++;
    endtask

    task automatic tick(input int gap);
        repeat (gap) cyc(1'b0, 1'b0, '0);
        cyc(1'b1, 1'b0, '0);
        line_q.push_back(sdo);
    endtask

    task automatic drain();
        int b;
        b = 0;
        while (sdoFinish !== 1'b1 && b < 3 * FRAME_LEN) begin
            tick(0);
            b++;
        end
        check("drain finish", sdoFinish, 1);
    endtask

    // Line level expected k tick periods into a frame.
    function automatic logic frame_bit(input logic [DB-1:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k <= DB) return d[k-1];
        if (PB == 1 && k == DB + 1) return (^d) ^ parityOdd;
        return 1'b1;
    endfunction

    typedef struct {
        logic          tk;
        logic          wr;
        logic [DB-1:0] data;
        logic          e_sdo, e_irq, e_ovr, e_busy, e_fin;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input logic tk, input logic wr, input logic [DB-1:0] d,
                       input logic s, input logic i, input logic o, input logic b, input logic f);
        vec_t v;
        v.tk = tk; v.wr = wr; v.data = d;
        v.e_sdo = s; v.e_irq = i; v.e_ovr = o; v.e_busy = b; v.e_fin = f;
        vecs.push_back(v);
    endtask

    initial begin
        logic [DB-1:0] sent[$];
        logic [DB-1:0] got[$];
        logic [DB-1:0] w;
        logic [DB-1:0] d;
        int idx, bad, target, budget;

        // Overrun then a frame of 0x22; ticks on every clock.
        //  tk wr data    sdo irq ovr busy fin
        add(0, 1, 8'h11,  1, 0, 0, 0, 0);
        add(0, 1, 8'h22,  1, 0, 1, 0, 0);
        add(0, 0, 8'h00,  1, 0, 0, 0, 0);
        add(1, 0, 8'h00,  0, 1, 0, 1, 0);
        add(1, 0, 8'h00,  0, 0, 0, 1, 0);
        add(1, 0, 8'h00,  1, 0, 0, 1, 0);
        add(1, 0, 8'h00,  0, 0, 0, 1, 0);
        add(1, 0, 8'h00,  0, 0, 0, 1, 0);
        add(1, 0, 8'h00,  0, 0, 0, 1, 0);
        add(1, 0, 8'h00,  1, 0, 0, 1, 0);
        add(1, 0, 8'h00,  0, 0, 0, 1, 0);
        add(1, 0, 8'h00,  0, 0, 0, 1, 0);
`ifdef SEROUT_PARITY_EN
        add(1, 0, 8'h00,  0, 0, 0, 1, 0);
        add(1, 0, 8'h00,  1, 0, 0, 1, 0);
        add(1, 0, 8'h00,  1, 0, 0, 1, 0);
`else
        add(1, 0, 8'h00,  1, 0, 0, 1, 0);
`endif
        add(1, 0, 8'h00,  1, 0, 0, 0, 1);

        // Reset idle
        nReset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset sdo held", sdo, 1);
        nReset = 1'b1;
        cyc(1'b0, 1'b0, '0);
        check("reset sdo", sdo, 1);
        check("reset finish", sdoFinish, 1);
        check("reset busy", sdoBusy, 0);
        check("reset irq", sdoEmptyIrq, 0);
        check("reset ovr", sdoOverrun, 0);

        // Table
        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].tk, vecs[i].wr, vecs[i].data);
            check($sformatf("vec%0d sdo", i), sdo, vecs[i].e_sdo);
            check($sformatf("vec%0d irq", i), sdoEmptyIrq, vecs[i].e_irq);
            check($sformatf("vec%0d ovr", i), sdoOverrun, vecs[i].e_ovr);
            check($sformatf("vec%0d busy", i), sdoBusy, vecs[i].e_busy);
            check($sformatf("vec%0d finish", i), sdoFinish, vecs[i].e_fin);
        end

        // Single frame 0x5A, tick every 16 clocks
        irq_cnt = 0;
        line_q.delete();
        cyc(1'b0, 1'b1, 8'h5A);
        for (int k = 0; k < FRAME_LEN; k++) begin
            tick(15);
            if (k == 0) check("single irq at first tick", irq_cnt, 1);
        end
        for (int k = 0; k < FRAME_LEN; k++)
            check($sformatf("single bit%0d", k), line_q[k], frame_bit(8'h5A, k));
        check("single finish before last tick", sdoFinish, 0);
        tick(15);
        check("single finish after stop", sdoFinish, 1);
        check("single busy after stop", sdoBusy, 0);
        check("single irq count", irq_cnt, 1);

        // Write and tick on the same idle edge
        line_q.delete();
        cyc(1'b1, 1'b1, 8'hC3);
        check("same-edge busy", sdoBusy, 0);
        check("same-edge sdo", sdo, 1);
        tick(2);
        check("same-edge start busy", sdoBusy, 1);
        check("same-edge start sdo", sdo, 0);
        for (int k = 1; k < FRAME_LEN; k++) tick(1);
        bad = 0;
        for (int k = 0; k < FRAME_LEN; k++)
            if (line_q[k] !== frame_bit(8'hC3, k)) bad++;
        check("same-edge frame bits", bad, 0);
        drain();

        // Back-to-back
        irq_cnt = 0;
        ovr_cnt = 0;
        line_q.delete();
        cyc(1'b0, 1'b1, 8'h01);
        tick(3);
        tick(3);
        tick(3);
        cyc(1'b0, 1'b1, 8'hFF);
        for (int k = 3; k < 2 * FRAME_LEN + 1; k++) tick(3);
        for (int k = 0; k < 2 * FRAME_LEN + 1; k++)
            check($sformatf("b2b bit%0d", k), line_q[k],
                  (k < FRAME_LEN) ? frame_bit(8'h01, k) :
                  (k < 2 * FRAME_LEN) ? frame_bit(8'hFF, k - FRAME_LEN) : 1'b1);
        check("b2b irq count", irq_cnt, 2);
        check("b2b overrun", ovr_cnt, 0);
        check("b2b finish", sdoFinish, 1);

`ifdef SEROUT_PARITY_EN
        begin
            logic [11:0] pexp;
            pexp = 12'b1110_0000_1110;
            line_q.delete();
            parityOdd = 1'b0;
            cyc(1'b0, 1'b1, 8'h07);
            for (int k = 0; k < 12; k++) tick(2);
            for (int k = 0; k < 12; k++)
                check($sformatf("parity bit%0d", k), line_q[k], pexp[k]);
            tick(2);
            check("parity finish", sdoFinish, 1);
        end
`endif

        // forceBreak: line low, timing unchanged
        forceBreak = 1'b1;
        cyc(1'b0, 1'b1, 8'h5A);
        check("break idle sdo", sdo, 0);
        bad = 0;
        for (int k = 0; k < FRAME_LEN; k++) begin
            tick(1);
            if (sdo !== 1'b0 || sdoBusy !== 1'b1) bad++;
        end
        check("break frame low and busy", bad, 0);
        tick(1);
        check("break finish on time", sdoFinish, 1);
        forceBreak = 1'b0;
        #1;
        check("break release sdo", sdo, 1);

        // Reset mid-frame during data bit 3
        cyc(1'b0, 1'b1, 8'h00);
        tick(1);
        for (int k = 0; k < 4; k++) tick(1);
        check("midreset pre sdo", sdo, 0);
        check("midreset pre busy", sdoBusy, 1);
        #2;
        nReset = 1'b0;
        #1;
        check("midreset async sdo", sdo, 1);
        check("midreset async busy", sdoBusy, 0);
        @(posedge clk);
        #1;
        nReset = 1'b1;
        bad = 0;
        for (int k = 0; k < 12; k++) begin
            tick(0);
            if (sdo !== 1'b1 || sdoBusy !== 1'b0) bad++;
        end
        check("midreset no resume", bad, 0);
        check("midreset finish", sdoFinish, 1);

        // Randomized traffic, decoded by a line receiver
        irq_cnt = 0;
        ovr_cnt = 0;
        line_q.delete();
        for (int n = 0; n < 20; n++) begin
            w = DB'($urandom);
            cyc(1'b0, 1'b1, w);
            sent.push_back(w);
            target = n + 1;
            budget = 0;
            while (irq_cnt < target && budget < 4 * FRAME_LEN) begin
                tick(int'($urandom_range(0, 3)));
                budget++;
            end
            if (irq_cnt < target) check("rand irq timeout", irq_cnt, target);
            if ($urandom_range(0, 1) == 1) drain();
        end
        drain();
        tick(0);
        tick(0);

        idx = 0;
        bad = 0;
        while (idx < line_q.size()) begin
            if (line_q[idx] === 1'b1) begin
                idx++;
                continue;
            end
            if (idx + FRAME_LEN > line_q.size()) begin
                bad++;
                break;
            end
            for (int j = 0; j < DB; j++) d[j] = line_q[idx + 1 + j];
            if (PB == 1 && line_q[idx + 1 + DB] !== ((^d) ^ parityOdd)) bad++;
            for (int s = 0; s < SB; s++)
                if (line_q[idx + 1 + DB + PB + s] !== 1'b1) bad++;
            got.push_back(d);
            idx += FRAME_LEN;
        end
        check("rand framing errors", bad, 0);
        check("rand word count", got.size(), sent.size());
        for (int i = 0; i < sent.size() && i < got.size(); i++)
            check($sformatf("rand word%0d", i), got[i], sent[i]);
        check("rand irq count", irq_cnt, sent.size());
        check("rand overrun", ovr_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
